lab6_seq_divider: RTL and testbench
===================================

// Module: lab6_seq_divider
// PURPOSE
//  Sequential restoring divider: the inverse companion of the Lab 6 adder/subtractor/multiplier datapath.
//  Takes N-bit dividend/divisor from the switch-register stage and produces quotient/remainder for the HEX displays.
//  Computes one quotient bit per clock, with a Start/Busy/Done handshake.
//  Supports unsigned and two's-complement signed operation, with overflow and divide-by-zero flags.
// PARAMETERS
//  N  8  operand, quotient and remainder width in bits (N >= 2)
// PORTS
//  Clock        in   1  system clock; all state changes on posedge
//  Reset        in   1  synchronous, active-high reset
//  Start        in   1  request; sampled only in IDLE
//  Signed_mode  in   1  1 = two's-complement operands, 0 = unsigned; sampled with Start
//  Dividend     in   N  sampled on the accepting edge
//  Divisor      in   N  sampled on the accepting edge
//  Quotient     out  N  result; held until the next completion
//  Remainder    out  N  result; held until the next completion
//  Busy         out  1  high while a division is in progress
//  Done         out  1  one-cycle pulse when results and flags update
//  Div_by_zero  out  1  flag for the last result; held
//  Overflow     out  1  signed -2^(N-1) / -1 flag for the last result; held
// BEHAVIOUR
//  Reset
//   - At a posedge with Reset=1: all outputs 0, state IDLE, internal registers cleared.
//   - Reset has priority over every other event, including mid-division; any operation in flight is aborted with no Done.
//  States: IDLE, CALC, FIX.
//  IDLE, Start=1 at edge k
//   - Latch Signed_mode and the signs of both operands.
//   - Latch the magnitudes |Dividend| and |Divisor| as N-bit unsigned. |-2^(N-1)| = 2^(N-1) fits.
//   - Clear the (N+1)-bit partial remainder. Set count=0, Busy=1, state CALC.
//  Divide by zero
//   - If Divisor==0 at edge k: no CALC.
//   - Quotient = all ones, Remainder = Dividend unchanged, Div_by_zero=1, Overflow=0.
//   - Done=1 for the cycle after edge k; Busy stays 0; state stays IDLE.
//  CALC (edges k+1 .. k+N)
//   - Shift {rem, dvd} left by 1.
//   - Trial subtract: rem - divisor_mag, (N+1)-bit.
//   - If non-negative: keep the difference and set quotient bit = 1. Otherwise restore and set bit = 0.
//   - count increments; after the Nth iteration go to FIX.
//  FIX (edge k+N+1)
//   - Quotient is negated iff signed and the operand signs differ.
//   - Remainder is negated iff signed and the dividend is negative. Quotient truncates toward zero; remainder takes the dividend's sign.
//   - Overflow=1 iff signed, Dividend = -2^(N-1) and Divisor = -1. Then Quotient = -2^(N-1) (wrapped) and Remainder = 0.
//   - Register Quotient, Remainder and flags. Done=1 for the following cycle only. Busy=0. Go to IDLE.
//  Latency and throughput
//   - Done is visible N+1 edges after the accepting edge; Busy is high for exactly N+1 cycles.
//   - Start while Busy=1 is ignored; operand changes during CALC have no effect.
//   - Start=1 in the same cycle as Done is accepted, giving back-to-back operation.
//   - Start held high restarts on every return to IDLE.
//   - Quotient, Remainder and flags change only at completion, or at reset.
// TESTING
//  - Reset=1 for 2 cycles -> all outputs 0. Start=1, U, 200/7 -> Busy 9 cycles; Done pulse with Q=28, R=4, flags 0.
//  - Start, signed, -100/7 (0x9C/0x07) -> Q=0xF2 (-14), R=0xFE (-2); 100/-7 -> Q=0xF2, R=0x02.
//  - Start, signed, 0x80/0xFF -> Q=0x80, R=0x00, Overflow=1; same operands unsigned -> Q=0x00, R=0x80, Overflow=0.
//  - Start, 55/0 -> next cycle Done=1, Q=0xFF, R=55, Div_by_zero=1, Busy never high.
//  - Start 200/7, then Start 9/3 at cycle 3 -> ignored, Q=28; Start 9/3 in the Done cycle -> Q=3, R=0 after 9 more cycles.
//  - Start 200/7, Reset=1 at cycle 5 -> outputs 0, no Done; next Start 250/16 -> Q=15, R=10.

Source files
------------

// File: rtl/lab6_seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, Start/Busy/Done handshake,
// unsigned or two's-complement operands, with divide-by-zero and overflow flags.
module lab6_seq_divider #(
    parameter int unsigned N = 8
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Start,
    input  logic         Signed_mode,
    input  logic [N-1:0] Dividend,
    input  logic [N-1:0] Divisor,
    output logic [N-1:0] Quotient,
    output logic [N-1:0] Remainder,
    output logic         Busy,
    output logic         Done,
    output logic         Div_by_zero,
    output logic         Overflow
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N - 1){1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]    state, state_nxt;
    logic          sgn, sgn_nxt;
    logic          dvd_neg, dvd_neg_nxt;
    logic          dsr_neg, dsr_neg_nxt;
    logic [N-1:0]  dvd, dvd_nxt;      // dividend magnitude, shifts into quotient magnitude
    logic [N-1:0]  dsr, dsr_nxt;      // divisor magnitude
    logic [N-1:0]  rem, rem_nxt;      // partial remainder, always below dsr between steps
    logic [CW-1:0] cnt, cnt_nxt;
    logic [N-1:0]  quot_nxt, rmd_nxt;
    logic          busy_nxt, done_nxt, dbz_nxt, ovf_nxt;

    logic [N:0]    shifted;
    logic [N:0]    trial;
    logic          ovf_c;

    // State and datapath registers; reset clears everything and aborts any operation
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= S_IDLE;
            sgn         <= 1'b0;
            dvd_neg     <= 1'b0;
            dsr_neg     <= 1'b0;
            dvd         <= '0;
            dsr         <= '0;
            rem         <= '0;
            cnt         <= '0;
            Quotient    <= '0;
            Remainder   <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Div_by_zero <= 1'b0;
            Overflow    <= 1'b0;
        end else begin
            state       <= state_nxt;
            sgn         <= sgn_nxt;
            dvd_neg     <= dvd_neg_nxt;
            dsr_neg     <= dsr_neg_nxt;
            dvd         <= dvd_nxt;
            dsr         <= dsr_nxt;
            rem         <= rem_nxt;
            cnt         <= cnt_nxt;
            Quotient    <= quot_nxt;
            Remainder   <= rmd_nxt;
            Busy        <= busy_nxt;
            Done        <= done_nxt;
            Div_by_zero <= dbz_nxt;
            Overflow    <= ovf_nxt;
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_nxt   = state;
        sgn_nxt     = sgn;
        dvd_neg_nxt = dvd_neg;
        dsr_neg_nxt = dsr_neg;
        dvd_nxt     = dvd;
        dsr_nxt     = dsr;
        rem_nxt     = rem;
        cnt_nxt     = cnt;
        quot_nxt    = Quotient;
        rmd_nxt     = Remainder;
        busy_nxt    = Busy;
        done_nxt    = 1'b0;
        dbz_nxt     = Div_by_zero;
        ovf_nxt     = Overflow;

        shifted = {rem, dvd[N-1]};
        trial   = shifted - {1'b0, dsr};
        // Same-sign operands with a 2^(N-1) magnitude quotient only arise from -2^(N-1) / -1
        ovf_c   = sgn & ~(dvd_neg ^ dsr_neg) & (dvd == MIN_NEG);

        case (state)
            S_IDLE: begin
                if (Start) begin
                    if (Divisor == '0) begin
                        quot_nxt = '1;
                        rmd_nxt  = Dividend;
                        dbz_nxt  = 1'b1;
                        ovf_nxt  = 1'b0;
                        done_nxt = 1'b1;
                    end else begin
                        sgn_nxt     = Signed_mode;
                        dvd_neg_nxt = Signed_mode & Dividend[N-1];
                        dsr_neg_nxt = Signed_mode & Divisor[N-1];
                        dvd_nxt     = dvd_neg_nxt ? N'(~Dividend + 1'b1) : Dividend;
                        dsr_nxt     = dsr_neg_nxt ? N'(~Divisor + 1'b1) : Divisor;
                        rem_nxt     = '0;
                        cnt_nxt     = '0;
                        busy_nxt    = 1'b1;
                        state_nxt   = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (!trial[N]) begin
                    rem_nxt = trial[N-1:0];
                    dvd_nxt = {dvd[N-2:0], 1'b1};
                end else begin
                    rem_nxt = shifted[N-1:0];
                    dvd_nxt = {dvd[N-2:0], 1'b0};
                end
                cnt_nxt = CW'(cnt + 1'b1);
                if (cnt == CW'(N - 1)) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                quot_nxt  = (sgn & (dvd_neg ^ dsr_neg)) ? N'(~dvd + 1'b1) : dvd;
                rmd_nxt   = (sgn & dvd_neg) ? N'(~rem + 1'b1) : rem;
                if (ovf_c) begin
                    quot_nxt = MIN_NEG;
                    rmd_nxt  = '0;
                end
                ovf_nxt   = ovf_c;
                dbz_nxt   = 1'b0;
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_lab6_seq_divider.sv
// Bench for lab6_seq_divider: directed scenarios plus random traffic, checked every cycle
// against a transaction-level arithmetic model with a busy countdown.
module tb_lab6_seq_divider;

    localparam int unsigned N = 8;

    logic         Clock = 1'b0;
    logic         Reset, Start, Signed_mode;
    logic [N-1:0] Dividend, Divisor, Quotient, Remainder;
    logic         Busy, Done, Div_by_zero, Overflow;

    always #5 Clock = ~Clock;

    lab6_seq_divider #(.N(N)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Signed_mode(Signed_mode),
        .Dividend(Dividend), .Divisor(Divisor), .Quotient(Quotient), .Remainder(Remainder),
        .Busy(Busy), .Done(Done), .Div_by_zero(Div_by_zero), .Overflow(Overflow)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state: visible outputs plus the result waiting for completion
    logic [N-1:0] m_q, m_r, p_q, p_r;
    logic         m_dbz, m_ov, m_done, p_dbz, p_ov;
    int           busy_left;

    function automatic void compute(input logic sm, input logic [N-1:0] a, input logic [N-1:0] b,
                                    output logic [N-1:0] q, output logic [N-1:0] r,
                                    output logic dbz, output logic ov);
        longint sa, sb, qq, rr;
        if (b == '0) begin
            q = '1; r = a; dbz = 1'b1; ov = 1'b0;
            return;
        end
        if (sm) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = a;
            sb = b;
        end
        qq  = sa / sb;
        rr  = sa % sb;
        q   = N'(qq);
        r   = N'(rr);
        dbz = 1'b0;
        ov  = sm && (qq == (longint'(1) << (N - 1)));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Advance one clock, update the model from the inputs held across that edge, compare all outputs
    task automatic step();
        logic [N-1:0] q, r;
        logic dbz, ov;
        @(posedge Clock);
        #1;
        if (Reset) begin
            m_q = '0; m_r = '0; m_dbz = 1'b0; m_ov = 1'b0; m_done = 1'b0; busy_left = 0;
        end else begin
            m_done = 1'b0;
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    m_q = p_q; m_r = p_r; m_dbz = p_dbz; m_ov = p_ov; m_done = 1'b1;
                end
            end else if (Start) begin
                compute(Signed_mode, Dividend, Divisor, q, r, dbz, ov);
                if (dbz) begin
                    m_q = q; m_r = r; m_dbz = 1'b1; m_ov = 1'b0; m_done = 1'b1;
                end else begin
                    p_q = q; p_r = r; p_dbz = dbz; p_ov = ov; busy_left = N + 1;
                end
            end
        end
        check("busy",        Busy,        busy_left > 0);
        check("done",        Done,        m_done);
        check("quotient",    Quotient,    m_q);
        check("remainder",   Remainder,   m_r);
        check("div_by_zero", Div_by_zero, m_dbz);
        check("overflow",    Overflow,    m_ov);
    endtask

    task automatic set_in(input logic st, input logic sm, input logic [N-1:0] a, input logic [N-1:0] b);
        Start = st; Signed_mode = sm; Dividend = a; Divisor = b;
    endtask

    // Issue one operation and run until Done (bounded), counting Busy cycles
    task automatic run_op(input logic sm, input logic [N-1:0] a, input logic [N-1:0] b,
                          output int busy_cycles);
        busy_cycles = 0;
        set_in(1'b1, sm, a, b);
        step();
        Start = 1'b0;
        for (int i = 0; i < 20 && !Done; i++) begin
            if (Busy) busy_cycles++;
            step();
        end
        check("done_reached", Done, 1'b1);
    endtask

    initial begin
        int bc;
        Reset = 1'b1;
        set_in(1'b0, 1'b0, '0, '0);
        step();
        step();
        check("reset_q", Quotient, 0);
        check("reset_busy", Busy, 0);
        Reset = 1'b0;
        step();

        run_op(1'b0, 8'd200, 8'd7, bc);
        check("u200_7_busy", bc, 9);
        check("u200_7_q", Quotient, 28);
        check("u200_7_r", Remainder, 4);

        run_op(1'b1, 8'h9C, 8'h07, bc);
        check("s_m100_7_q", Quotient, 8'hF2);
        check("s_m100_7_r", Remainder, 8'hFE);
        run_op(1'b1, 8'd100, 8'hF9, bc);
        check("s_100_m7_q", Quotient, 8'hF2);
        check("s_100_m7_r", Remainder, 8'h02);

        run_op(1'b1, 8'h80, 8'hFF, bc);
        check("ovf_q", Quotient, 8'h80);
        check("ovf_r", Remainder, 8'h00);
        check("ovf_flag", Overflow, 1);
        run_op(1'b0, 8'h80, 8'hFF, bc);
        check("u80_ff_q", Quotient, 8'h00);
        check("u80_ff_r", Remainder, 8'h80);
        check("u80_ff_ovf", Overflow, 0);

        run_op(1'b0, 8'd55, 8'd0, bc);
        check("dbz_busy", bc, 0);
        check("dbz_q", Quotient, 8'hFF);
        check("dbz_r", Remainder, 8'd55);
        check("dbz_flag", Div_by_zero, 1);
        step();

        // Start while busy is ignored; Start during the Done cycle is accepted
        set_in(1'b1, 1'b0, 8'd200, 8'd7);
        step();
        Start = 1'b0;
        step();
        set_in(1'b1, 1'b0, 8'd9, 8'd3);
        step();
        Start = 1'b0;
        for (int i = 0; i < 20 && !Done; i++) step();
        check("ignored_q", Quotient, 28);
        run_op(1'b0, 8'd9, 8'd3, bc);
        check("b2b_busy", bc, 9);
        check("b2b_q", Quotient, 3);
        check("b2b_r", Remainder, 0);

        // Reset mid-division aborts with no Done
        set_in(1'b1, 1'b0, 8'd200, 8'd7);
        step();
        Start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("abort_q", Quotient, 0);
        for (int i = 0; i < 12; i++) step();
        run_op(1'b0, 8'd250, 8'd16, bc);
        check("u250_16_q", Quotient, 15);
        check("u250_16_r", Remainder, 10);

        // Random traffic, operands biased toward corner values, occasional reset
        for (int i = 0; i < 1500; i++) begin
            logic [N-1:0] a, b;
            case ($urandom_range(0, 5))
                0: a = 8'h80;
                1: a = 8'h00;
                2: a = 8'hFF;
                default: a = N'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: b = 8'h00;
                1: b = 8'hFF;
                2: b = 8'h01;
                default: b = N'($urandom);
            endcase
            Reset = ($urandom_range(0, 149) == 0);
            set_in($urandom_range(0, 2) == 0, 1'($urandom), a, b);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
